// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port DMEM arbiter: access-size codes,
// FSM states, the latched command record and the access legality check.
package dmem_arbiter_pkg;

  localparam logic [31:0] MEM_SIZE_DEFAULT = 32'h0000_8000;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // One accepted request, frozen for the whole transaction.
  typedef struct packed {
    logic        we;
    size_e       size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  // True when the access must be refused without touching memory:
  // illegal size, misaligned address, or running past the end of DMEM.
  // The end address is formed in 33 bits so addresses near 2^32 cannot wrap.
  function automatic logic is_bad_access(input cmd_t cmd, input logic [31:0] mem_size);
    logic        misaligned;
    logic [32:0] end_addr;
    case (cmd.size)
      SIZE_HALF: misaligned = cmd.addr[0];
      SIZE_WORD: misaligned = |cmd.addr[1:0];
      default:   misaligned = 1'b0;
    endcase
    end_addr = {1'b0, cmd.addr} + {30'd0, size_bytes(cmd.size)};
    return (cmd.size == SIZE_BAD) || misaligned || (end_addr > {1'b0, mem_size});
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake of the DMEM arbiter. One instance per requester;
// the requester drives the command and holds it until done, the arbiter
// answers with a one-cycle done/err pulse and a held load result.
interface dmem_arbiter_if;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, addr, wdata,
    input  done, err, rdata
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output done, err, rdata
  );

endinterface

// File: rtl/dmem_arbiter_lane_merge.sv
// Big-endian lane steering between a full DMEM word and a right-aligned
// byte/halfword: builds the read-modify-write word for subword stores and
// extracts the zero-extended value for subword loads. Purely combinational.
module dmem_arbiter_lane_merge
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  a,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [31:0] lane_mask;
  logic [4:0]  shift;

  // Lane select: byte a=0 sits in [31:24] (shift 24 = (3-a)*8), half a=0 in
  // [31:16] (shift 16 = (2-a)*8); a word uses every lane unshifted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    lane_mask = 32'hFFFF_FFFF;
    shift     = 5'd0;
    case (size)
      SIZE_BYTE: begin
        lane_mask = 32'h0000_00FF;
        shift     = {~a, 3'b000};
      end
      SIZE_HALF: begin
        lane_mask = 32'h0000_FFFF;
        shift     = {~a[1], 4'b0000};
      end
      default: ;
    endcase
  end

  assign merged    = (rd_word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
  assign extracted = (rd_word >> shift) & lane_mask;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of a word-wide,
// big-endian DMEM. Subword stores become read-modify-write sequences, subword
// loads are extracted and zero-extended, illegal accesses are answered with
// err and never reach memory. Every output comes straight from a register.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     r0,
  dmem_arbiter_if.slave     r1,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  // Sequencer state and per-transaction context.
  state_e      state, state_d;
  logic        last_grant, last_grant_d;
  logic        grant, grant_d;
  cmd_t        cmd, cmd_d;
  logic [31:0] rd_word, rd_word_d;

  // Registered outputs and their next values.
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];
  logic [31:0] mem_address_d, mem_write_data_d;
  logic        mem_write_d, mem_read_d;

  // Arbitration view of the incoming requests.
  logic        win;
  cmd_t        req_cmd;
  logic        req_bad;
  logic        req_word_store;

  // Lane steering operands and results.
  logic [31:0] lane_word;
  logic [31:0] merged_word;
  logic [31:0] extracted_word;

  // Round robin: on a tie the requester that did not win last time goes next;
  // otherwise the single active requester wins.
  assign win = (r0.req && r1.req) ? ~last_grant : r1.req;

  // Candidate command of the current winner, with its legality and path.
  always_comb begin
    req_cmd.we    = win ? r1.we    : r0.we;
    req_cmd.size  = size_e'(win ? r1.size : r0.size);
    req_cmd.addr  = win ? r1.addr  : r0.addr;
    req_cmd.wdata = win ? r1.wdata : r0.wdata;
  end

  assign req_bad        = is_bad_access(req_cmd, MEM_SIZE);
  assign req_word_store = req_cmd.we && (req_cmd.size == SIZE_WORD);

  // In RD the fresh DMEM word is steered directly, so the merged store word
  // and the load result are ready at the same edge that captures rd_word.
  assign lane_word = (state == ST_RD) ? mem_read_data : rd_word;

  dmem_arbiter_lane_merge u_lane_merge (
    .rd_word   (lane_word),
    .wdata     (cmd.wdata),
    .size      (cmd.size),
    .a         (cmd.addr[1:0]),
    .merged    (merged_word),
    .extracted (extracted_word)
  );

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    state_d          = state;
    last_grant_d     = last_grant;
    grant_d          = grant;
    cmd_d            = cmd;
    rd_word_d        = rd_word;
    mem_address_d    = mem_address;
    mem_write_data_d = mem_write_data;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    done_d           = 2'b00;
    err_d            = 2'b00;
    rdata_d          = rdata_q;

    case (state)
      ST_IDLE: begin
        if (r0.req || r1.req) begin
          grant_d      = win;
          last_grant_d = win;
          cmd_d        = req_cmd;
          if (req_bad) begin
            state_d     = ST_RESP;
            done_d[win] = 1'b1;
            err_d[win]  = 1'b1;
          end else begin
            mem_address_d = {req_cmd.addr[31:2], 2'b00};
            if (req_word_store) begin
              state_d          = ST_WR;
              mem_write_d      = 1'b1;
              mem_write_data_d = req_cmd.wdata;
            end else begin
              state_d    = ST_RD;
              mem_read_d = 1'b1;
            end
          end
        end
      end

      ST_RD: begin
        rd_word_d = mem_read_data;
        if (cmd.we) begin
          state_d          = ST_WR;
          mem_write_d      = 1'b1;
          mem_write_data_d = merged_word;
        end else begin
          state_d          = ST_RESP;
          done_d[grant]    = 1'b1;
          rdata_d[grant]   = extracted_word;
        end
      end

      ST_WR: begin
        state_d       = ST_RESP;
        done_d[grant] = 1'b1;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, context and output registers; reset abandons any transaction
  // without a done, and a partially completed RMW never reaches WR.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    if (reset) begin
      state          <= ST_IDLE;
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      cmd            <= '0;
      rd_word        <= '0;
      done_q         <= 2'b00;
      err_q          <= 2'b00;
      rdata_q[0]     <= '0;
      rdata_q[1]     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      state          <= state_d;
      last_grant     <= last_grant_d;
      grant          <= grant_d;
      cmd            <= cmd_d;
      rd_word        <= rd_word_d;
      done_q         <= done_d;
      err_q          <= err_d;
      rdata_q[0]     <= rdata_d[0];
      rdata_q[1]     <= rdata_d[1];
      mem_address    <= mem_address_d;
      mem_write_data <= mem_write_data_d;
      mem_write      <= mem_write_d;
      mem_read       <= mem_read_d;
    end
  end

  assign r0.done  = done_q[0];
  assign r0.err   = err_q[0];
  assign r0.rdata = rdata_q[0];
  assign r1.done  = done_q[1];
  assign r1.err   = err_q[1];
  assign r1.rdata = rdata_q[1];

  // DMEM is never asked to read and write in the same cycle, and only one
  // requester is ever answered at a time.
  a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(mem_read && mem_write));
  a_done_onehot : assert property (@(posedge clk) disable iff (reset)
    !(done_q[0] && done_q[1]));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-array DMEM behind the arbiter,
// a byte-level reference memory for expected results, a directed vector table,
// hand sequences for arbitration and reset abort, and randomized traffic.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam logic [31:0] MEM_SIZE  = 32'h0000_8000;
  localparam int          MEM_BYTES = 32'h8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  dmem_arbiter_if r0_if ();
  dmem_arbiter_if r1_if ();

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk            (clk),
    .reset          (reset),
    .r0             (r0_if),
    .r1             (r1_if),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // DMEM: big-endian byte array, combinational read, commit on negedge.
  logic [7:0] dmem    [MEM_BYTES] = '{default: 8'h00};
  logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

  always_comb begin
    mem_read_data = 32'h0;
    if (mem_read)
      for (int k = 0; k < 4; k++)
        mem_read_data = {mem_read_data[23:0], dmem[(int'(mem_address[14:0]) & ~3) + k]};
  end

  int mem_ops   = 0;
  int overlap   = 0;
  int both_done = 0;

  always @(negedge clk) begin
    if (mem_write)
      for (int k = 0; k < 4; k++)
        dmem[(int'(mem_address[14:0]) & ~3) + k] = mem_write_data[31 - 8*k -: 8];
    if (mem_read || mem_write) mem_ops++;
    if (mem_read && mem_write) overlap++;
    if (r0_if.done && r1_if.done) both_done++;
  end

  logic [1:0] done_v, err_v;
  assign done_v = {r1_if.done, r0_if.done};
  assign err_v  = {r1_if.err, r0_if.err};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic p, input logic req, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin
      r1_if.req = req; r1_if.we = we; r1_if.size = size; r1_if.addr = addr; r1_if.wdata = wdata;
    end else begin
      r0_if.req = req; r0_if.we = we; r0_if.size = size; r0_if.addr = addr; r0_if.wdata = wdata;
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic p);
    return p ? r1_if.rdata : r0_if.rdata;
  endfunction

  // Reference: byte-granular memory; latency and DMEM access count follow
  // from the access kind (error 1/0, load 2/1, word store 2/1, subword 3/2).
  task automatic model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic e, output logic [31:0] rd,
                       output int lat, output int ops);
    int n;
    n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e  = (size == 2'b11) || ((addr % n) != 0) || (longint'(addr) + n > longint'(MEM_SIZE));
    rd = 32'h0;
    if (e) begin
      lat = 1; ops = 0;
    end else if (!we) begin
      for (int k = 0; k < n; k++) rd = (rd << 8) | 32'(ref_mem[int'(addr) + k]);
      lat = 2; ops = 1;
    end else begin
      for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = wdata[8*(n-1-k) +: 8];
      lat = (n == 4) ? 2 : 3;
      ops = (n == 4) ? 1 : 2;
    end
  endtask

  // One transaction: raise req in an idle cycle, count cycles to done,
  // drop req in the done cycle. Bounded wait.
  task automatic run_txn(input logic p, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic got, output logic e, output logic [31:0] rd,
                         output int lat, output int ops, output int stray);
    int ops0;
    @(negedge clk);
    drive(p, 1'b1, we, size, addr, wdata);
    ops0 = mem_ops; got = 1'b0; e = 1'b0; rd = 32'h0; lat = 0; stray = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done_v[~p] || err_v[~p]) stray++;
      if (done_v[p]) begin
        got = 1'b1; e = err_v[p]; rd = rdata_of(p); lat = c;
        break;
      end
    end
    drive(p, 1'b0, we, size, addr, wdata);
    ops = mem_ops - ops0;
  endtask

  task automatic exec_check(input string name, input bit from_model, input logic p, input logic we,
                            input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    logic m_err; logic [31:0] m_rd; int m_lat, m_ops;
    logic got, e; logic [31:0] rd; int lat, ops, stray;
    model(we, size, addr, wdata, m_err, m_rd, m_lat, m_ops);
    if (from_model) begin
      exp_err = m_err; exp_rd = m_rd; exp_lat = m_lat;
    end
    run_txn(p, we, size, addr, wdata, got, e, rd, lat, ops, stray);
    check({name, " done"}, 32'(got), 32'd1);
    check({name, " err"}, 32'(e), 32'(exp_err));
    check({name, " latency"}, lat, exp_lat);
    check({name, " mem accesses"}, ops, m_ops);
    check({name, " stray done"}, stray, 0);
    if (!we && !exp_err) check({name, " rdata"}, rd, exp_rd);
  endtask

  typedef struct {
    logic        p;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int          order [$];
    int          cnt   [2];
    bit          rearm [2];
    logic [31:0] tie_rd [2];
    logic        seen;
    int          mism;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          pick;

    vecs[0]  = '{1'b0, 1'b1, 2'b10, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        2};
    vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 2};
    vecs[2]  = '{1'b1, 1'b1, 2'b00, 32'h12,   32'h00000055, 1'b0, 32'h0,        3};
    vecs[3]  = '{1'b1, 1'b0, 2'b10, 32'h10,   32'h0,        1'b0, 32'hDEAD55EF, 2};
    vecs[4]  = '{1'b0, 1'b0, 2'b01, 32'h12,   32'h0,        1'b0, 32'h000055EF, 2};
    vecs[5]  = '{1'b0, 1'b0, 2'b00, 32'h11,   32'h0,        1'b0, 32'h000000AD, 2};
    vecs[6]  = '{1'b1, 1'b1, 2'b01, 32'h10,   32'hFFFF1234, 1'b0, 32'h0,        3};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'h13,   32'hFFFFFF77, 1'b0, 32'h0,        3};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 32'h10,   32'h0,        1'b0, 32'h12345577, 2};
    vecs[9]  = '{1'b0, 1'b0, 2'b01, 32'h11,   32'h0,        1'b1, 32'h0,        1};
    vecs[10] = '{1'b1, 1'b1, 2'b10, 32'h12,   32'hAAAAAAAA, 1'b1, 32'h0,        1};
    vecs[11] = '{1'b0, 1'b0, 2'b11, 32'h10,   32'h0,        1'b1, 32'h0,        1};
    vecs[12] = '{1'b1, 1'b0, 2'b10, 32'h7FFE, 32'h0,        1'b1, 32'h0,        1};
    vecs[13] = '{1'b0, 1'b1, 2'b10, 32'h7FFC, 32'hCAFEF00D, 1'b0, 32'h0,        2};
    vecs[14] = '{1'b1, 1'b0, 2'b00, 32'h7FFF, 32'h0,        1'b0, 32'h0000000D, 2};
    vecs[15] = '{1'b0, 1'b0, 2'b01, 32'h7FFE, 32'h0,        1'b0, 32'h0000F00D, 2};

    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // Reset state: every output low.
    repeat (3) @(negedge clk);
    check("reset done", 32'(done_v), 32'h0);
    check("reset err", 32'(err_v), 32'h0);
    check("reset r0 rdata", r0_if.rdata, 32'h0);
    check("reset r1 rdata", r1_if.rdata, 32'h0);
    check("reset mem_address", mem_address, 32'h0);
    check("reset mem_write_data", mem_write_data, 32'h0);
    check("reset mem_rd_wr", {30'd0, mem_read, mem_write}, 32'h0);
    reset = 1'b0;

    // Both requesters active from the same cycle for four transactions:
    // round 1 word stores, round 2 each loads the other's word.
    void'(order.size());
    cnt[0] = 0; cnt[1] = 0; rearm[0] = 0; rearm[1] = 0;
    tie_rd[0] = 32'h0; tie_rd[1] = 32'h0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h40, 32'h0A0B0C0D);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h44, 32'h1B2B3B4B);
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rearm[i]) begin
          drive(1'(i), 1'b1, 1'b0, 2'b10, (i == 0) ? 32'h44 : 32'h40, 32'h0);
          rearm[i] = 1'b0;
        end else if (done_v[i]) begin
          order.push_back(i);
          tie_rd[i] = rdata_of(1'(i));
          cnt[i]++;
          drive(1'(i), 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
          if (cnt[i] < 2) rearm[i] = 1'b1;
        end
      end
    end
    ref_mem[32'h40] = 8'h0A; ref_mem[32'h41] = 8'h0B; ref_mem[32'h42] = 8'h0C; ref_mem[32'h43] = 8'h0D;
    ref_mem[32'h44] = 8'h1B; ref_mem[32'h45] = 8'h2B; ref_mem[32'h46] = 8'h3B; ref_mem[32'h47] = 8'h4B;
    check("tie grant count", order.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("tie grant %0d", k), (k < order.size()) ? order[k] : -1, k % 2);
    check("tie r0 load", tie_rd[0], 32'h1B2B3B4B);
    check("tie r1 load", tie_rd[1], 32'h0A0B0C0D);

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      exec_check($sformatf("vec%0d", i), 1'b0, vecs[i].p, vecs[i].we, vecs[i].size,
                 vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_lat);
      if (i == 0)
        check("vec0 dmem bytes", {dmem[16], dmem[17], dmem[18], dmem[19]}, 32'hDEADBEEF);
    end

    // Reset in the RD cycle of a byte store: no done, memory untouched.
    exec_check("rst setup", 1'b0, 1'b0, 1'b1, 2'b10, 32'h20, 32'h11223344, 1'b0, 32'h0, 2);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'h21, 32'h00000099);
    @(negedge clk);
    check("rst in rd cycle", 32'(mem_read), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    seen = |done_v;
    check("rst mem_address", mem_address, 32'h0);
    check("rst r0 rdata", r0_if.rdata, 32'h0);
    repeat (4) begin
      @(negedge clk);
      seen = seen | (|done_v);
    end
    check("rst no done", 32'(seen), 32'h0);
    check("rst word intact", {dmem[32], dmem[33], dmem[34], dmem[35]}, 32'h11223344);
    exec_check("rst reload", 1'b0, 1'b0, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 32'h11223344, 2);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 80; i++) begin
      pick = $urandom_range(0, 9);
      sz   = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 7) == 0) ad = MEM_SIZE - 32'd8 + 32'($urandom_range(0, 11));
      else                           ad = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1 && sz != 2'b11)
        ad = ad & ~((sz == 2'b00) ? 32'h0 : (sz == 2'b01) ? 32'h1 : 32'h3);
      exec_check($sformatf("rand%0d", i), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 sz, ad, $urandom, 1'b0, 32'h0, 0);
    end

    // Whole-run properties and final memory image.
    check("rd/wr overlap cycles", overlap, 0);
    check("simultaneous done cycles", both_done, 0);
    mism = 0;
    for (int k = 0; k < MEM_BYTES; k++) if (dmem[k] !== ref_mem[k]) mism++;
    check("memory image", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
